// File: rtl/countdown_timer_core.sv
// Countdown timer core: edits a min:sec:hundredths value in packed BCD from
// one-cycle button pulses, then counts it down to zero and flags the time-out.
// Every output comes straight from a register.
module countdown_timer_core #(
  parameter int TICK_DIV = 1
) (
  input  logic       clk_core,
  input  logic       rst,
  input  logic       left_button,
  input  logic       right_button,
  input  logic       up_button,
  input  logic       down_button,
  input  logic       center_button,
  output logic [7:0] min_o,
  output logic [7:0] sec_o,
  output logic [7:0] ms_10_o,
  output logic [1:0] target,
  output logic       time_out_o
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_EDIT    = 2'd0,
    S_RUN     = 2'd1,
    S_PAUSE   = 2'd2,
    S_TIMEOUT = 2'd3
  } state_t;

  state_t        state_q;
  logic [7:0]    min_q, sec_q, ms_q;
  logic [7:0]    pre_min_q, pre_sec_q, pre_ms_q;
  logic [1:0]    target_q;
  logic          time_out_q;
  logic [PW-1:0] presc_q;

  logic [7:0]    min_dec_d, sec_dec_d, ms_dec_d;
  logic          dec_zero_d;
  logic          val_zero;
  logic          presc_term;

  // BCD increment that wraps from maxv back to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] maxv);
    if (v == maxv)            return 8'h00;
    else if (v[3:0] == 4'd9)  return {v[7:4] + 4'd1, 4'd0};
    else                      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // BCD decrement that wraps from 00 up to maxv.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] maxv);
    if (v == 8'h00)           return maxv;
    else if (v[3:0] == 4'd0)  return {v[7:4] - 4'd1, 4'd9};
    else                      return {v[7:4], v[3:0] - 4'd1};
  endfunction

  assign val_zero   = (min_q == 8'h00) && (sec_q == 8'h00) && (ms_q == 8'h00);
  assign presc_term = (presc_q == PRESC_LAST);

  // Value minus 10 ms with borrow chain ms_10 -> sec -> min; only used while nonzero.
  always_comb begin
    ms_dec_d  = bcd_dec(ms_q, 8'h99);
    sec_dec_d = sec_q;
    min_dec_d = min_q;
    if (ms_q == 8'h00) begin
      sec_dec_d = bcd_dec(sec_q, 8'h59);
      if (sec_q == 8'h00) begin
        min_dec_d = bcd_dec(min_q, 8'h99);
      end
    end
    dec_zero_d = (min_dec_d == 8'h00) && (sec_dec_d == 8'h00) && (ms_dec_d == 8'h00);
  end

  // Mode FSM plus value/preset/prescaler registers; center outranks every other button.
  always_ff @(posedge clk_core or posedge rst) begin
    if (rst) begin
      state_q    <= S_EDIT;
      min_q      <= 8'h00;
      sec_q      <= 8'h00;
      ms_q       <= 8'h00;
      pre_min_q  <= 8'h00;
      pre_sec_q  <= 8'h00;
      pre_ms_q   <= 8'h00;
      target_q   <= 2'b00;
      time_out_q <= 1'b0;
      presc_q    <= '0;
    end else begin
      case (state_q)
        S_EDIT: begin
          if (center_button) begin
            // A zero value cannot be counted down, so start is refused.
            if (!val_zero) begin
              pre_min_q <= min_q;
              pre_sec_q <= sec_q;
              pre_ms_q  <= ms_q;
              target_q  <= 2'b11;
              presc_q   <= '0;
              state_q   <= S_RUN;
            end
          end else if (left_button) begin
            target_q <= (target_q == 2'b00) ? 2'b10 :
                        (target_q == 2'b10) ? 2'b01 : 2'b00;
          end else if (right_button) begin
            target_q <= (target_q == 2'b00) ? 2'b01 :
                        (target_q == 2'b01) ? 2'b10 : 2'b00;
          end else if (up_button) begin
            case (target_q)
              2'b00:   min_q <= bcd_inc(min_q, 8'h99);
              2'b01:   sec_q <= bcd_inc(sec_q, 8'h59);
              2'b10:   ms_q  <= bcd_inc(ms_q, 8'h99);
              default: ;
            endcase
          end else if (down_button) begin
            case (target_q)
              2'b00:   min_q <= bcd_dec(min_q, 8'h99);
              2'b01:   sec_q <= bcd_dec(sec_q, 8'h59);
              2'b10:   ms_q  <= bcd_dec(ms_q, 8'h99);
              default: ;
            endcase
          end
        end
        S_RUN: begin
          if (center_button) begin
            state_q <= S_PAUSE;
          end else if (presc_term) begin
            presc_q <= '0;
            min_q   <= min_dec_d;
            sec_q   <= sec_dec_d;
            ms_q    <= ms_dec_d;
            if (dec_zero_d) begin
              state_q    <= S_TIMEOUT;
              time_out_q <= 1'b1;
            end
          end else begin
            presc_q <= presc_q + 1'b1;
          end
        end
        S_PAUSE: begin
          if (center_button) begin
            state_q <= S_RUN;
          end else if (left_button) begin
            min_q    <= pre_min_q;
            sec_q    <= pre_sec_q;
            ms_q     <= pre_ms_q;
            target_q <= 2'b00;
            state_q  <= S_EDIT;
          end
        end
        default: begin
          if (center_button || left_button) begin
            min_q      <= pre_min_q;
            sec_q      <= pre_sec_q;
            ms_q       <= pre_ms_q;
            target_q   <= 2'b00;
            time_out_q <= 1'b0;
            state_q    <= S_EDIT;
          end
        end
      endcase
    end
  end

  assign min_o      = min_q;
  assign sec_o      = sec_q;
  assign ms_10_o    = ms_q;
  assign target     = target_q;
  assign time_out_o = time_out_q;

endmodule
